// File: rtl/seg7_scan_decoder.sv
// Receive side of the active-low 7-segment scan bus: debounces each (anode, segment)
// pair, decodes it back to BCD and hands out one assembled frame per full scan.
module seg7_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [4*DIGITS-1:0]   frame_bcd,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE);
    localparam logic [DIGITS-1:0] LSB_D   = DIGITS'(1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic [DIGITS-1:0]   an_q, an_prev_q;
    logic [6:0]          seg_q, seg_prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] slot_bcd_q, slot_bcd_d;
    logic [DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [DIGITS-1:0]   seen_q, seen_d, seen_next;
    logic                comp_q, complete;
    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] frame_bcd_q, frame_bcd_d;
    logic [DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;

    logic [DIGITS-1:0]   an_low;
    logic                same, fire, onehot, capture;
    logic [4:0]          dec;
    logic                accept;

    // {error, nibble}; all-dark is a blank digit, anything unknown decodes to E.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = {1'b0, 4'h0};
            7'b1001111: decode = {1'b0, 4'h1};
            7'b0010010: decode = {1'b0, 4'h2};
            7'b0000110: decode = {1'b0, 4'h3};
            7'b1001100: decode = {1'b0, 4'h4};
            7'b0100100: decode = {1'b0, 4'h5};
            7'b0100000: decode = {1'b0, 4'h6};
            7'b0001111: decode = {1'b0, 4'h7};
            7'b0000000: decode = {1'b0, 4'h8};
            7'b0000100: decode = {1'b0, 4'h9};
            7'b1111111: decode = {1'b0, 4'hF};
            default:    decode = {1'b1, 4'hE};
        endcase
    endfunction

    always_comb begin
        an_low = ~an_q;
        same   = (an_q == an_prev_q) && (seg_q == seg_prev_q);
        if (!same)
            cnt_d = CNT_ONE;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_ONE;
        // Fires only on the transition into STABLE, so long holds capture once.
        fire    = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
        onehot  = (an_low != '0) && ((an_low & (an_low - LSB_D)) == '0);
        capture = fire && onehot;
        dec     = decode(seg_q);

        slot_bcd_d = slot_bcd_q;
        slot_err_d = slot_err_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && an_low[i]) begin
                slot_bcd_d[4*i +: 4] = dec[3:0];
                slot_err_d[i]        = dec[4];
            end
        end
        seen_next = seen_q | (capture ? an_low : '0);
        complete  = &seen_next;
        seen_d    = complete ? '0 : seen_next;
    end

    always_comb begin
        state_d     = state_q;
        frame_bcd_d = frame_bcd_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        accept      = (state_q == FULL) && frame_ready;
        case (state_q)
            EMPTY: begin
                if (comp_q) begin
                    frame_bcd_d = slot_bcd_q;
                    frame_err_d = slot_err_q;
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    overrun_d = 1'b0;
                    if (comp_q) begin
                        frame_bcd_d = slot_bcd_q;
                        frame_err_d = slot_err_q;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (comp_q) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q        <= '1;
            seg_q       <= '1;
            an_prev_q   <= '1;
            seg_prev_q  <= '1;
            cnt_q       <= '0;
            slot_bcd_q  <= '0;
            slot_err_q  <= '0;
            seen_q      <= '0;
            comp_q      <= 1'b0;
            state_q     <= EMPTY;
            frame_bcd_q <= '0;
            frame_err_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            an_q        <= an;
            seg_q       <= seg;
            an_prev_q   <= an_q;
            seg_prev_q  <= seg_q;
            cnt_q       <= cnt_d;
            slot_bcd_q  <= slot_bcd_d;
            slot_err_q  <= slot_err_d;
            seen_q      <= seen_d;
            comp_q      <= complete;
            state_q     <= state_d;
            frame_bcd_q <= frame_bcd_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_valid = (state_q == FULL);
    assign frame_bcd   = frame_bcd_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

- Recovers BCD digit values by observing a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables).
- Uses the same segment encoding the team's BCD-to-7-segment encoder produces, so it is the receive side of that encoding.
- Debounces each (anode, segment) pair, decodes it to a nibble and assembles one nibble per digit into a frame.
- Hands the frame out over a valid/ready handshake; sits between the board display bus and the self-check/readback logic.

## Interface
- DIGITS, 4: number of multiplexed digits; legal range 1-8.
- STABLE, 4: consecutive identical samples needed before a capture; minimum 2.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- an  in  DIGITS  anode enables, active-low; exactly one bit low selects a digit.
- seg  in  7  segments {a,b,c,d,e,f,g} on bits [6:0], active-low.
- frame_valid  out  1  frame_bcd/frame_err hold a complete frame.
- frame_ready  in  1  consumer accepts the frame when frame_valid is also high.
- frame_bcd  out  4*DIGITS  digit i in bits [4i+3:4i].
- frame_err  out  DIGITS  bit i high means digit i had an illegal pattern.
- overrun  out  1  sticky: a completed frame was dropped because the output was full.

## Operation
- Input stage: an and seg are registered once; reset value an = all ones, seg = 7'b1111111.
- Stability counter:
  - Compares each sample with the previous sample; equal increments (saturating at STABLE), different reloads to 1.
  - A capture fires exactly once, in the sample where the counter first reaches STABLE.
  - A pair held longer than STABLE samples still gives only one capture; held fewer gives none.
- Capture qualification: inhibited unless an is one-hot-low. All-ones or multiple-low samples are ignored but still advance the counter.
- Decode table (seg -> nibble):
  - 0000001 -> 0; 1001111 -> 1; 0010010 -> 2; 0000110 -> 3; 1001100 -> 4.
  - 0100100 -> 5; 0100000 -> 6; 0001111 -> 7; 0000000 -> 8; 0000100 -> 9.
  - 1111111 -> F (blank, not an error).
  - Any other pattern -> E, with the digit's error bit set.
- Capture writes slot i (i = index of the low an bit) with the nibble and error bit, and sets seen[i].
  - Re-capturing a slot within a frame overwrites it; the latest value wins.
- Frame completion happens when seen becomes all ones, counting the capture in the current cycle.
  - seen clears to 0 on completion in every case.
- Output FSM, two states:
  - EMPTY: on completion, load frame_bcd/frame_err from the slots and go to FULL.
  - FULL: frame_valid = 1 and the outputs hold stable.
  - FULL -> EMPTY on frame_valid && frame_ready.
  - Completion while FULL with no acceptance that cycle: drop the new frame and set overrun.
  - Acceptance and completion in the same cycle: load the new frame and stay FULL; overrun is not set.
- overrun clears on the cycle after an acceptance, unless a drop occurs in that same acceptance cycle (not possible by the rule above).
- Reset, including mid-scan, returns to EMPTY with:
  - frame_valid = 0, frame_bcd = 0, frame_err = 0, overrun = 0;
  - seen = 0, counter = 0, all slots = 0.

## Timing
- Sampling:
  - A new stable pair is first seen at edge e1.
  - Its slot is written at edge e(STABLE+1).
- Frame output:
  - If that capture completes the frame, frame_valid is high after edge e(STABLE+2).
  - Frame latency from the last digit change is STABLE+2 cycles.
- Throughput: one capture per digit per stable window; one frame per full scan.
- Handshake:
  - frame_valid never drops without acceptance.
  - Outputs do not change while frame_valid && !frame_ready.
- frame_ready is don't-care while frame_valid = 0.

## Test plan
- Reset: hold rst_n low 2 cycles with an = 4'b1110, seg = 0000000 -> frame_valid = 0, frame_bcd = 16'h0000, frame_err = 0, overrun = 0; no capture occurs during reset.
- Nominal (DIGITS = 4, STABLE = 4), frame_ready = 1, each pair held 8 cycles:
  - stimulus: an 1110/0010010, 1101/0000110, 1011/1001100, 0111/0000001;
  - response: frame_valid high STABLE+2 cycles after the last change, frame_bcd = 16'h0432, frame_err = 0, one frame per scan.
- Glitch:
  - Digit 1 held 3 cycles -> no capture and no frame.
  - Same pair then held 4 cycles -> captured; frame follows once the other slots are seen.
- Illegal and blank:
  - Digit 2 = 1111110 -> nibble 2 = E, frame_err = 4'b0100.
  - Digit 3 = 1111111 -> nibble 3 = F, frame_err bit 3 = 0.
- Backpressure:
  - frame_ready = 0 across two full scans -> first frame held unchanged and overrun = 1.
  - Pulse frame_ready -> frame_valid drops next cycle and overrun clears.
- Mid-scan reset: capture digits 0-1, pulse rst_n low 1 cycle, then scan digits 2-3 only -> no frame until digits 0-1 are recaptured.
